// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Mult/div ops issue from IDLE, hold busy for a fixed cycle count, then
// write HI/LO. MTHI/MTLO load HI/LO directly; MFHI/MFLO read them.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | accepting ops; MTHI/MTLO and mult/div issue take effect here
//   RUN   | counting down; HI/LO written on the edge where counter == 1
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       MD_op,
  input  logic             req,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MD_result
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             is_md_op, is_mult_op, issue, done;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  // Issue decode; reset blocks issue so a same-edge MULT is dropped
  always_comb begin
    is_md_op   = (MD_op == OP_MULT) || (MD_op == OP_MULTU) ||
                 (MD_op == OP_DIV)  || (MD_op == OP_DIVU);
    is_mult_op = (MD_op == OP_MULT) || (MD_op == OP_MULTU);
    issue      = is_md_op && (state_q == S_IDLE) && !req && !reset;
    done       = (state_q == S_RUN) && (cnt_q == CW'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_RUN;
      S_RUN:   if (done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and the HI/LO read port
  always_comb begin
    busy     = (state_q == S_RUN);
    md_stall = busy || issue;
    HI       = hi_q;
    LO       = lo_q;
    case (MD_op)
      OP_MFHI: MD_result = hi_q;
      OP_MFLO: MD_result = lo_q;
      default: MD_result = '0;
    endcase
  end

  // Result from the captured operands; the signed overflow case and
  // divide-by-zero are handled explicitly instead of relying on '/'
  always_comb begin
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic signed [WIDTH-1:0]   as, bs;
    as     = $signed(a_q);
    bs     = $signed(b_q);
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        if (b_q != '0) begin
          res_wr = 1'b1;
          if (a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1) begin
            res_lo = a_q;
            res_hi = '0;
          end else begin
            res_lo = $unsigned(as / bs);
            res_hi = $unsigned(as % bs);
          end
        end
      end
      OP_DIVU: begin
        if (b_q != '0) begin
          res_wr = 1'b1;
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: operand capture, countdown, HI/LO writes
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (issue) begin
      a_d   = A;
      b_d   = B;
      op_d  = MD_op;
      cnt_d = is_mult_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (done && res_wr) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end
    if (state_q == S_IDLE && !req) begin
      if (MD_op == OP_MTHI) hi_d = A;
      if (MD_op == OP_MTLO) lo_d = A;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, HI, LO, MD_result;
  logic [3:0]  MD_op;
  logic        req, busy, md_stall;

  logic [15:0] a16, b16, hi16, lo16, res16;
  logic [3:0]  op16;
  logic        req16, busy16, stall16;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MD_op(MD_op), .req(req),
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO), .MD_result(MD_result)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .MD_op(op16), .req(req16),
    .busy(busy16), .md_stall(stall16), .HI(hi16), .LO(lo16), .MD_result(res16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit rq);
    bit issue;
    int exp_n, n;
    logic [31:0] pre_hi, pre_lo;
    A = a; B = b; MD_op = op; req = rq;
    #1;
    issue = (op >= 4'd1 && op <= 4'd4) && !rq;
    exp_n = issue ? ((op <= 4'd2) ? 5 : 10) : 0;
    chk("stall_at_issue", 64'(md_stall), 64'(issue));
    if (op == 4'd5)      chk("mfhi_idle", 64'(MD_result), 64'(m_hi));
    else if (op == 4'd6) chk("mflo_idle", 64'(MD_result), 64'(m_lo));
    else                 chk("result_zero", 64'(MD_result), 64'd0);
    pre_hi = m_hi;
    pre_lo = m_lo;
    if (!rq) model_exec(op, a, b);
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 1) chk("stall_in_run", 64'(md_stall), 64'd1);
      A = $urandom; B = $urandom;
      MD_op = 4'($urandom_range(0, 8));
      req = 1'($urandom_range(0, 1));
      #1;
      if (MD_op == 4'd5) chk("mfhi_in_run", 64'(MD_result), 64'(pre_hi));
      if (MD_op == 4'd6) chk("mflo_in_run", 64'(MD_result), 64'(pre_lo));
      @(negedge clk);
    end
    MD_op = 4'd0; req = 1'b0;
    chk("busy_cycles", 64'(n), 64'(exp_n));
    chk("hi", 64'(HI), 64'(m_hi));
    chk("lo", 64'(LO), 64'(m_lo));
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] ra, rb;
    reset = 1'b1; A = 0; B = 0; MD_op = 4'd0; req = 1'b0;
    a16 = 0; b16 = 0; op16 = 4'd0; req16 = 1'b0;
    m_hi = 0; m_lo = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(md_stall), 64'd0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult_neg_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(LO), 64'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_hi", 64'(HI), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(LO), 64'h0000_0001);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(HI), 64'hFFFF_FFFF);
    run_op(4'd7, 32'h55, 0, 0);
    run_op(4'd8, 32'h55, 0, 0);
    run_op(4'd4, 32'd7, 32'd0, 0);
    chk("divu0_hi", 64'(HI), 64'h55);
    chk("divu0_lo", 64'(LO), 64'h55);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_lo", 64'(LO), 64'h8000_0000);
    chk("div_ovf_hi", 64'(HI), 64'h0);
    run_op(4'd7, 32'h1234_5678, 0, 1);
    run_op(4'd7, 32'h1234_5678, 0, 0);
    run_op(4'd5, 0, 0, 0);
    chk("mthi_hi", 64'(HI), 64'h1234_5678);

    // Reset two cycles into a MULT; result must never land
    A = 32'd3; B = 32'd4; MD_op = 4'd1;
    @(negedge clk); MD_op = 4'd1; A = 32'd9;
    @(negedge clk); reset = 1'b1; MD_op = 4'd0;
    @(negedge clk); reset = 1'b0;
    m_hi = 0; m_lo = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    chk("abort_busy_late", 64'(busy), 64'd0);

    // Reset coinciding with a MULT request
    reset = 1'b1; MD_op = 4'd1; A = 32'd5; B = 32'd5;
    @(negedge clk); reset = 1'b0; MD_op = 4'd0;
    chk("rst_mult_busy", 64'(busy), 64'd0);

    // Narrow instance with a one-cycle multiply
    a16 = 16'h8000; b16 = 16'h8000; op16 = 4'd1;
    @(negedge clk); op16 = 4'd0; a16 = 16'h1111;
    n = 0;
    while (busy16 && n < 10) begin n++; @(negedge clk); end
    chk("w16_busy_cycles", 64'(n), 64'd1);
    chk("w16_hi", 64'(hi16), 64'h4000);
    chk("w16_lo", 64'(lo16), 64'h0000);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 20)) - 32'd10;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(op, ra, rb, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
